// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding and default parameters for the run controller
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      IDLE = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      TRAP = 3'd4
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_HOLD_CYCLES = 4;
   localparam bit DEF_AUTO_RUN    = 1'b1;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_STEP_W      = 16;
   localparam int DEF_WDT_CYCLES  = 1000;

endpackage

// File: rtl/core_run_ctrl_if.sv
// rtl/core_run_ctrl_if.sv - request/status bundle between a host and the run controller
interface core_run_ctrl_if
   import core_ctrl_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int STEP_W = DEF_STEP_W
);
   logic              run_req;
   logic              halt_req;
   logic              step_req;
   logic [STEP_W-1:0] step_count;
   logic              core_halt;
   logic              wdt_kick;
   logic              core_reset;
   logic              core_en;
   logic [CNT_W-1:0]  cycle_count;
   logic [2:0]        state;
   logic              timeout;

   // host side: issues requests, observes the core controls
   modport master (
      output run_req, halt_req, step_req, step_count, core_halt, wdt_kick,
      input  core_reset, core_en, cycle_count, state, timeout
   );

   // controller side
   modport slave (
      input  run_req, halt_req, step_req, step_count, core_halt, wdt_kick,
      output core_reset, core_en, cycle_count, state, timeout
   );
endinterface

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - asynchronous-assert, synchronous-release reset synchroniser
module reset_sync
   import core_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   output logic rst_sync_n
);
   logic [STAGES-1:0] sync_q;

   // shift ones in after release; any low on reset clears the whole chain at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_n = sync_q[STAGES-1];
endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - reset sequencing, clock-enable gating, cycle counter and watchdog for the datapath
module core_run_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter bit AUTO_RUN    = DEF_AUTO_RUN,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int STEP_W      = DEF_STEP_W,
   parameter int WDT_CYCLES  = DEF_WDT_CYCLES
) (
   input logic            clk,
   input logic            reset,
   core_run_ctrl_if.slave bus
);
   localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam int WDT_W  = $clog2(WDT_CYCLES);

   logic              rst_sync_n;
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic [WDT_W-1:0]  wdt_q, wdt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              core_reset_q, core_reset_d;
   logic              core_en_q, core_en_d;
   logic              timeout_q, timeout_d;
   logic              wdt_expire;
   logic              stop_req;

   reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
      .clk        (clk),
      .reset      (reset),
      .rst_sync_n (rst_sync_n)
   );

   // expiry is judged on the count this enabled edge would produce; a kick always defuses it
   assign wdt_expire = core_en_q && !bus.wdt_kick && (wdt_q == WDT_W'(WDT_CYCLES - 2));
   assign stop_req   = bus.halt_req || bus.core_halt;

   // next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      rem_d        = rem_q;
      wdt_d        = wdt_q;
      core_reset_d = 1'b0;
      core_en_d    = 1'b0;
      timeout_d    = timeout_q;
      cnt_d        = cnt_q;

      if (core_en_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (core_en_q) begin
         wdt_d = bus.wdt_kick ? '0 : wdt_q + WDT_W'(1);
      end

      case (state_q)
         HOLD: begin
            core_reset_d = 1'b1;
            wdt_d        = '0;
            if (!rst_sync_n) begin
               hold_d = '0;
            end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
               hold_d       = '0;
               core_reset_d = 1'b0;
               if (AUTO_RUN) begin
                  state_d   = RUN;
                  core_en_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         IDLE: begin
            wdt_d = '0;
            if (bus.halt_req) begin
               state_d = IDLE;
            end else if (bus.step_req) begin
               if (bus.step_count != '0) begin
                  rem_d     = bus.step_count;
                  state_d   = STEP;
                  core_en_d = 1'b1;
               end
            end else if (bus.run_req) begin
               state_d   = RUN;
               core_en_d = 1'b1;
            end
         end
         RUN: begin
            if (wdt_expire) begin
               state_d   = TRAP;
               timeout_d = 1'b1;
            end else if (stop_req) begin
               state_d = IDLE;
               wdt_d   = '0;
            end else begin
               core_en_d = 1'b1;
            end
         end
         STEP: begin
            rem_d = rem_q - STEP_W'(1);
            if (wdt_expire) begin
               state_d   = TRAP;
               timeout_d = 1'b1;
            end else if (stop_req || (rem_q == STEP_W'(1))) begin
               state_d = IDLE;
               wdt_d   = '0;
            end else begin
               core_en_d = 1'b1;
            end
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d      = HOLD;
            core_reset_d = 1'b1;
         end
      endcase
   end

   // state and counter registers; raw reset clears everything immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HOLD;
         hold_q       <= '0;
         rem_q        <= '0;
         wdt_q        <= '0;
         cnt_q        <= '0;
         core_reset_q <= 1'b1;
         core_en_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         rem_q        <= rem_d;
         wdt_q        <= wdt_d;
         cnt_q        <= cnt_d;
         core_reset_q <= core_reset_d;
         core_en_q    <= core_en_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.core_reset  = core_reset_q;
   assign bus.core_en     = core_en_q;
   assign bus.cycle_count = cnt_q;
   assign bus.state       = state_q;
   assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl across four parameter sets
module tb_core_run_ctrl;
   import core_ctrl_pkg::*;

   typedef struct {
      logic        run;
      logic        halt;
      logic        step;
      logic [15:0] sc;
      logic        chalt;
      logic        kick;
      logic [2:0]  st;
      logic        en;
      logic [31:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic [3:0]  rst_n = 4'b0000;
   logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
   logic [15:0] step_count = '0;
   logic        core_halt = 1'b0, wdt_kick = 1'b0;
   int          sel = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   vec_t        vecs[$];
   vec_t        sb[$];

   logic        o_rst, o_en, o_to;
   logic [2:0]  o_st;
   logic [31:0] o_cnt;

   always #5 clk = ~clk;

   core_run_ctrl_if #(.CNT_W(32), .STEP_W(16)) if0 ();
   core_run_ctrl_if #(.CNT_W(32), .STEP_W(16)) if1 ();
   core_run_ctrl_if #(.CNT_W(32), .STEP_W(16)) if2 ();
   core_run_ctrl_if #(.CNT_W(4),  .STEP_W(16)) if3 ();

   assign if0.run_req = run_req;  assign if0.halt_req = halt_req; assign if0.step_req = step_req;
   assign if0.step_count = step_count; assign if0.core_halt = core_halt; assign if0.wdt_kick = wdt_kick;
   assign if1.run_req = run_req;  assign if1.halt_req = halt_req; assign if1.step_req = step_req;
   assign if1.step_count = step_count; assign if1.core_halt = core_halt; assign if1.wdt_kick = wdt_kick;
   assign if2.run_req = run_req;  assign if2.halt_req = halt_req; assign if2.step_req = step_req;
   assign if2.step_count = step_count; assign if2.core_halt = core_halt; assign if2.wdt_kick = wdt_kick;
   assign if3.run_req = run_req;  assign if3.halt_req = halt_req; assign if3.step_req = step_req;
   assign if3.step_count = step_count; assign if3.core_halt = core_halt; assign if3.wdt_kick = wdt_kick;

   core_run_ctrl u0 (.clk(clk), .reset(rst_n[0]), .bus(if0));
   core_run_ctrl #(.AUTO_RUN(1'b0)) u1 (.clk(clk), .reset(rst_n[1]), .bus(if1));
   core_run_ctrl #(.WDT_CYCLES(8)) u2 (.clk(clk), .reset(rst_n[2]), .bus(if2));
   core_run_ctrl #(.CNT_W(4)) u3 (.clk(clk), .reset(rst_n[3]), .bus(if3));

   // route the instance under test onto a common set of observation signals
   always_comb begin
      o_rst = 1'b0; o_en = 1'b0; o_to = 1'b0; o_st = 3'd0; o_cnt = '0;
      case (sel)
         0: begin o_rst = if0.core_reset; o_en = if0.core_en; o_to = if0.timeout; o_st = if0.state; o_cnt = if0.cycle_count; end
         1: begin o_rst = if1.core_reset; o_en = if1.core_en; o_to = if1.timeout; o_st = if1.state; o_cnt = if1.cycle_count; end
         2: begin o_rst = if2.core_reset; o_en = if2.core_en; o_to = if2.timeout; o_st = if2.state; o_cnt = if2.cycle_count; end
         default: begin o_rst = if3.core_reset; o_en = if3.core_en; o_to = if3.timeout; o_st = if3.state; o_cnt = {28'd0, if3.cycle_count}; end
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      run_req = 0; halt_req = 0; step_req = 0; step_count = '0; core_halt = 0; wdt_kick = 0;
   endtask

   function automatic vec_t mk(input logic r, input logic h, input logic s, input logic [15:0] sc,
                               input logic ch, input logic k, input logic [2:0] st, input logic en,
                               input logic [31:0] cnt);
      vec_t v;
      v.run = r; v.halt = h; v.step = s; v.sc = sc; v.chalt = ch; v.kick = k;
      v.st = st; v.en = en; v.cnt = cnt;
      return v;
   endfunction

   // drive each vector before an edge, queue its expectation, compare after the edge
   task automatic apply_vecs(input string tag);
      vec_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         run_req = vecs[i].run; halt_req = vecs[i].halt; step_req = vecs[i].step;
         step_count = vecs[i].sc; core_halt = vecs[i].chalt; wdt_kick = vecs[i].kick;
         sb.push_back(vecs[i]);
         tick();
         e = sb.pop_front();
         chk($sformatf("%s%0d_state", tag, i), 32'(o_st), 32'(e.st));
         chk($sformatf("%s%0d_en", tag, i), 32'(o_en), 32'(e.en));
         chk($sformatf("%s%0d_cnt", tag, i), o_cnt, e.cnt);
      end
      clear_inputs();
      vecs.delete();
   endtask

   // hold reset three cycles, check the reset state, then follow the release sequence edge by edge
   task automatic do_release(input int inst, input logic [2:0] exp_st);
      logic [2:0] es;
      sel = inst;
      clear_inputs();
      rst_n[inst] = 1'b0;
      repeat (3) tick();
      chk("rst_core_reset", 32'(o_rst), 32'd1);
      chk("rst_core_en", 32'(o_en), 32'd0);
      chk("rst_cnt", o_cnt, 32'd0);
      chk("rst_state", 32'(o_st), 32'(HOLD));
      chk("rst_timeout", 32'(o_to), 32'd0);
      rst_n[inst] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         es = (e < 6) ? 3'd0 : exp_st;
         chk($sformatf("rel_e%0d_core_reset", e), 32'(o_rst), (e < 6) ? 32'd1 : 32'd0);
         chk($sformatf("rel_e%0d_state", e), 32'(o_st), 32'(es));
         chk($sformatf("rel_e%0d_en", e), 32'(o_en), (e == 6 && exp_st == 3'd2) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      tick();

      // free-run bring-up with default parameters
      do_release(0, RUN);
      repeat (10) tick();
      chk("run10_cnt", o_cnt, 32'd10);

      // core_halt stops counting; run_req resumes from the same value
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0,0,0,0,0,0, RUN, 1, 32'(11 + i)));
      vecs.push_back(mk(0,0,0,0,1,0, IDLE, 0, 21));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 21));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 21));
      vecs.push_back(mk(1,0,0,0,0,0, RUN,  1, 21));
      vecs.push_back(mk(0,0,0,0,0,0, RUN,  1, 22));
      vecs.push_back(mk(0,1,0,0,0,0, IDLE, 0, 23));
      apply_vecs("halt");

      // single-step and request priorities with AUTO_RUN off
      do_release(1, IDLE);
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0, IDLE, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 0));
      vecs.push_back(mk(0,0,1,5,0,0, STEP, 1, 0));
      vecs.push_back(mk(0,0,0,0,0,0, STEP, 1, 1));
      vecs.push_back(mk(0,0,0,0,0,0, STEP, 1, 2));
      vecs.push_back(mk(0,0,0,0,0,0, STEP, 1, 3));
      vecs.push_back(mk(0,0,0,0,0,0, STEP, 1, 4));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 5));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 5));
      vecs.push_back(mk(1,1,0,0,0,0, IDLE, 0, 5));
      vecs.push_back(mk(1,0,1,2,0,0, STEP, 1, 5));
      vecs.push_back(mk(0,0,0,0,1,0, IDLE, 0, 6));
      vecs.push_back(mk(1,0,0,0,0,0, RUN,  1, 6));
      vecs.push_back(mk(0,0,1,3,0,0, RUN,  1, 7));
      vecs.push_back(mk(0,1,0,0,0,0, IDLE, 0, 8));
      vecs.push_back(mk(0,0,0,0,0,0, IDLE, 0, 8));
      apply_vecs("step");

      // asynchronous reset in the middle of a step with three cycles left
      step_req = 1; step_count = 16'd10;
      tick();
      clear_inputs();
      repeat (7) tick();
      chk("midstep_state", 32'(o_st), 32'(STEP));
      #3;
      rst_n[1] = 1'b0;
      #1;
      chk("async_core_reset", 32'(o_rst), 32'd1);
      chk("async_core_en", 32'(o_en), 32'd0);
      chk("async_cnt", o_cnt, 32'd0);
      chk("async_state", 32'(o_st), 32'(HOLD));
      tick();
      do_release(1, IDLE);

      // watchdog trap after seven unkicked cycles, with halt_req on the expiry edge
      do_release(2, RUN);
      repeat (6) tick();
      chk("wdt_pre_state", 32'(o_st), 32'(RUN));
      chk("wdt_pre_timeout", 32'(o_to), 32'd0);
      halt_req = 1;
      tick();
      halt_req = 0;
      chk("wdt_trap_state", 32'(o_st), 32'(TRAP));
      chk("wdt_trap_timeout", 32'(o_to), 32'd1);
      chk("wdt_trap_en", 32'(o_en), 32'd0);
      chk("wdt_trap_cnt", o_cnt, 32'd7);
      run_req = 1; step_req = 1; step_count = 16'd3;
      repeat (4) tick();
      clear_inputs();
      chk("trap_hold_state", 32'(o_st), 32'(TRAP));
      chk("trap_hold_en", 32'(o_en), 32'd0);
      chk("trap_hold_cnt", o_cnt, 32'd7);

      // regular kicks keep the watchdog quiet
      do_release(2, RUN);
      for (int i = 0; i < 100; i++) begin
         wdt_kick = (i % 5 == 4);
         tick();
      end
      wdt_kick = 0;
      chk("kick_state", 32'(o_st), 32'(RUN));
      chk("kick_timeout", 32'(o_to), 32'd0);
      chk("kick_cnt", o_cnt, 32'd100);

      // narrow counter saturates instead of wrapping
      do_release(3, RUN);
      repeat (14) tick();
      chk("sat14_cnt", o_cnt, 32'd14);
      repeat (6) tick();
      chk("sat20_cnt", o_cnt, 32'd15);
      chk("sat20_en", 32'(o_en), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Parametrised clock-domain run controller for the single-cycle datapath.
- Successor to the fixed clock/reset stimulus currently used to bring up `datapath`.
- Takes the board/bench reset, synchronises its release, and holds the core in reset for a programmable number of cycles.
- Then gates the core with a clock enable in one of three modes: free-run, N-cycle single-step, or halted. Adds a cycle counter and a watchdog trap.

Parameters:
- SYNC_STAGES, 2: flops in the reset-release synchroniser (min 2).
- HOLD_CYCLES, 4: cycles `core_reset` stays high after synchronised release (min 1).
- AUTO_RUN, 1: 1 = enter RUN after hold; 0 = enter IDLE.
- CNT_W, 32: width of `cycle_count`.
- STEP_W, 16: width of `step_count`.
- WDT_CYCLES, 1000: enabled cycles without `wdt_kick` before trap (min 2).

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- run_req, input, 1: request free-run.
- halt_req, input, 1: request stop.
- step_req, input, 1: request `step_count` enabled cycles.
- step_count, input, STEP_W: number of cycles to step; sampled with `step_req`.
- core_halt, input, 1: halt indication from the datapath.
- wdt_kick, input, 1: clears the watchdog.
- core_reset, output, 1: active-high reset to the datapath.
- core_en, output, 1: clock enable to the datapath.
- cycle_count, output, CNT_W: count of enabled cycles since reset.
- state, output, 3: current FSM state.
- timeout, output, 1: sticky watchdog trap flag.

Behaviour:
- **Reset assertion** (`reset`=0), asynchronous and immediate:
  - Synchroniser cleared; state=HOLD.
  - `core_reset`=1, `core_en`=0, `cycle_count`=0, `timeout`=0.
  - Step and watchdog counters = 0.
  - This applies mid-RUN or mid-STEP too: no completion of an in-flight step.
- **Reset release:**
  - The synchroniser shifts in 1; `rst_sync_n` rises on edge SYNC_STAGES after `reset` goes high.
  - The hold counter then counts HOLD_CYCLES edges.
  - `core_reset` falls at edge SYNC_STAGES+HOLD_CYCLES, and state leaves HOLD on that same edge.
- **State encoding:** HOLD=0, IDLE=1, RUN=2, STEP=3, TRAP=4. All outputs are registered.
- **HOLD:**
  - Exits to RUN if AUTO_RUN=1, otherwise to IDLE.
  - `core_en`=0 throughout.
- **IDLE:**
  - Exit priority: `halt_req` (stay IDLE) > `step_req` > `run_req`.
  - `step_req` with `step_count`=0 is a no-op; stay IDLE.
  - `step_req` with `step_count`=N>0 loads `remaining`=N and goes to STEP.
  - `run_req` goes to RUN.
  - The request is sampled at edge k; `core_en`=1 from edge k+1.
- **RUN:**
  - `core_en`=1.
  - `halt_req` or `core_halt` goes to IDLE; `core_en`=0 from the next cycle.
  - `run_req` and `step_req` are ignored.
- **STEP:**
  - `core_en`=1 for exactly N cycles, then IDLE.
  - `remaining` decrements each enabled cycle; the transition to IDLE happens on the edge where `remaining`==1.
  - `halt_req` or `core_halt` aborts to IDLE immediately (fewer than N cycles).
- **cycle_count:**
  - +1 on each edge where `core_en`=1.
  - Saturates at all-ones; no wrap.
- **Watchdog:**
  - Counts edges with `core_en`=1 in RUN or STEP.
  - Cleared by `wdt_kick`; `wdt_kick` has priority over the increment in the same cycle.
  - Cleared on entry to IDLE.
  - When the count reaches WDT_CYCLES-1 on an enabled edge: state goes to TRAP, `timeout`=1, `core_en`=0.
- **TRAP:**
  - Absorbing: all requests are ignored.
  - Exit only via `reset`.
  - `cycle_count` is frozen.
- **Simultaneous events:**
  - `halt_req` with the watchdog expiry: TRAP wins.
  - `core_halt` with `remaining`==1: IDLE (the same result either way).
- **Requests during HOLD:** ignored; they are not queued.

Decomposition:
- **Shared package `core_ctrl_pkg`:**
  - State encoding constants: HOLD, IDLE, RUN, STEP, TRAP, 3 bits.
  - Default parameter constants.
- **Sub-module `reset_sync`:**
  - Parameter STAGES.
  - Inputs: `clk`, `reset` (active-low, async).
  - Output: `rst_sync_n`.
  - Asserts asynchronously, releases synchronously.
- The FSM, counters and watchdog stay in `core_run_ctrl`.

Test Plan:
1. Defaults, `reset`=0 for 3 cycles then 1 → `core_reset`=1 and `core_en`=0 through edge 5; `core_reset`=0, state=RUN and `core_en`=1 after edge 6; `cycle_count`=10 ten cycles later.
2. AUTO_RUN=0, `step_req` with `step_count`=5 → `core_en` high exactly 5 cycles; `cycle_count`=5; state back to IDLE. `step_count`=0 → no enable, state stays IDLE.
3. RUN, then `core_halt` pulse at cycle 20 → `core_en`=0 from cycle 21, state=IDLE, `cycle_count` frozen. A later `run_req` resumes counting from the same value.
4. WDT_CYCLES=8, RUN with no kick → `timeout`=1 and state=TRAP after 7 enabled cycles; `run_req`/`step_req` ignored. With `wdt_kick` every 5 cycles → no trap over 100 cycles.
5. `reset` driven 0 mid-STEP (`remaining`=3) between clock edges → `core_reset`=1, `core_en`=0, `cycle_count`=0 immediately without waiting for an edge; the release sequence then repeats as in scenario 1.
6. CNT_W=4, free-run 20 cycles → `cycle_count` saturates at 15.
